sample_u_stream: RTL

Parametrised, streaming centred-uniform coefficient sampler. Consumes a packed random bit stream in DIN_W-bit words, extracts LANES coefficients of runtime-selectable width u per beat, centres each to [-2^(u-1), 2^(u-1)-1], and lifts negatives into [0, Q) by adding Q. It sits between the XOF/PRNG output and the polynomial memory writer. It generalises the fixed 8-bit and 41-bit paths to any u in 1..U_MAX, with bit-level packing across word boundaries, valid/ready back-pressure and a coefficient count.

---
 rtl/sample_u_stream.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sample_u_stream.sv
// Streaming centred-uniform sampler: unpacks u-bit fields from a packed random
// bit stream, centres them around zero and lifts negatives into [0, Q).
module sample_u_stream #(
    parameter int            DIN_W = 48,
    parameter int            U_MAX = 41,
    parameter int            LANES = 2,
    parameter int            QW    = 49,
    parameter logic [QW-1:0] Q     = 49'h1f41002f80001,
    parameter int            CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [5:0]          u,
    input  logic [CNT_W-1:0]    n_coeff,
    input  logic [DIN_W-1:0]    din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [LANES*QW-1:0] dout,
    output logic [LANES-1:0]    dout_lanes,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BUF_W  = DIN_W + LANES*U_MAX;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int SW     = U_MAX + 1;
    localparam int RB_W   = CNT_W + 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          state;
    logic [5:0]          u_q;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    ext_cnt;
    logic [BUF_W-1:0]    bit_buf;
    logic [FILL_W-1:0]   fill;
    logic [RB_W-1:0]     rem_bits;

    logic [LANES*SW-1:0] s_data;
    logic [LANES-1:0]    s_lanes;
    logic                s_valid;
    logic                s_last;
    logic                dout_last;

    logic                en;
    logic                acc;
    logic                ext;
    logic                last_ext;
    logic [CNT_W-1:0]    remaining;
    logic [CNT_W-1:0]    lanes_now;
    logic [FILL_W-1:0]   ext_bits;
    logic [FILL_W-1:0]   fill_after;
    logic [FILL_W-1:0]   fill_next;
    logic [BUF_W-1:0]    buf_next;
    logic [LANES*SW-1:0] s_next;
    logic [LANES-1:0]    lane_mask;
    logic [LANES*QW-1:0] lifted;

    // din_ready is a function of registered state only, so no valid->ready path.
    assign busy      = (state != IDLE);
    assign en        = !dout_valid || dout_ready;
    assign remaining = n_q - ext_cnt;
    assign lanes_now = (remaining >= CNT_W'(LANES)) ? CNT_W'(LANES) : remaining;
    assign ext_bits  = FILL_W'(lanes_now * CNT_W'(u_q));
    assign din_ready = (state == RUN) && (fill <= FILL_W'(LANES*U_MAX)) && (rem_bits != '0);
    assign acc       = din_valid && din_ready;
    assign ext       = (state == RUN) && en && (fill >= ext_bits);
    assign last_ext  = ext && ((ext_cnt + lanes_now) == n_q);

    // Extraction shifts the buffer down first; a word accepted in the same
    // cycle lands directly above whatever is left.
    assign fill_after = ext ? fill - ext_bits : fill;
    assign fill_next  = fill_after + (acc ? FILL_W'(DIN_W) : '0);
    assign buf_next   = (ext ? (bit_buf >> ext_bits) : bit_buf)
                      | (acc ? (BUF_W'(din) << fill_after) : '0);

    always_comb begin
        logic [BUF_W-1:0] shifted;
        logic [SW-1:0]    msk;
        logic [SW-1:0]    mid;
        logic [SW-1:0]    x;
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch. Blocking '=' is
        // correct here because this is combinational logic, not state.
        s_next    = '0;
        lane_mask = '0;
        msk       = (SW'(1) << u_q) - SW'(1);
        mid       = SW'(1) << (u_q - 6'd1);
        for (int k = 0; k < LANES; k++) begin
            shifted = bit_buf >> (FILL_W'(k) * FILL_W'(u_q));
            x       = shifted[SW-1:0] & msk;
            if (CNT_W'(k) < lanes_now) begin
                lane_mask[k]        = 1'b1;
                s_next[k*SW +: SW]  = (x ^ mid) - mid;
            end
        end
    end

    always_comb begin
        logic signed [SW-1:0] sk;
        logic signed [QW-1:0] se;
        lifted = '0;
        for (int k = 0; k < LANES; k++) begin
            sk = s_data[k*SW +: SW];
            se = sk;
            lifted[k*QW +: QW] = se + (Q & {QW{sk[SW-1]}});
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            u_q      <= '0;
            n_q      <= '0;
            ext_cnt  <= '0;
            bit_buf  <= '0;
            fill     <= '0;
            rem_bits <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (u == '0 || u > 6'(U_MAX) || n_coeff == '0) begin
                            err <= 1'b1;
                        end else begin
                            u_q      <= u;
                            n_q      <= n_coeff;
                            ext_cnt  <= '0;
                            bit_buf  <= '0;
                            fill     <= '0;
                            rem_bits <= RB_W'(n_coeff) * RB_W'(u);
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    bit_buf <= buf_next;
                    fill    <= fill_next;
                    if (acc)
                        rem_bits <= (rem_bits > RB_W'(DIN_W)) ? rem_bits - RB_W'(DIN_W) : '0;
                    if (ext)
                        ext_cnt <= ext_cnt + lanes_now;
                    if (last_ext)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (dout_valid && dout_ready && dout_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage pipeline; both stages freeze together when the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data     <= '0;
            s_lanes    <= '0;
            s_valid    <= 1'b0;
            s_last     <= 1'b0;
            dout       <= '0;
            dout_lanes <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else if (en) begin
            s_valid    <= ext;
            s_last     <= last_ext;
            s_lanes    <= ext ? lane_mask : '0;
            s_data     <= ext ? s_next : '0;
            dout_valid <= s_valid;
            dout_last  <= s_last;
            dout_lanes <= s_lanes;
            dout       <= lifted;
        end
    end

endmodule
